// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter plus registered command stage sharing one data memory
// between the CPU load/store path and a debug/loader port (with debug lock).
module data_mem_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic                  cpu_gnt,
   output logic                  cpu_stall,
   output logic                  cpu_rvalid,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   input  logic                  dbg_req,
   input  logic                  dbg_we,
   input  logic [ADDR_WIDTH-1:0] dbg_addr,
   input  logic [DATA_WIDTH-1:0] dbg_wdata,
   input  logic                  dbg_lock,
   output logic                  dbg_gnt,
   output logic                  dbg_rvalid,
   output logic [DATA_WIDTH-1:0] dbg_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_wd,
   input  logic [DATA_WIDTH-1:0] mem_rd
);

   typedef enum logic {ARB, LOCKED} state_e;
   typedef enum logic {OWN_CPU, OWN_DBG} owner_e;

   state_e                state_q, state_d;
   owner_e                last_winner_q, last_winner_d;
   logic                  cmd_valid_q, cmd_valid_d;
   owner_e                cmd_owner_q, cmd_owner_d;
   logic                  cmd_we_q, cmd_we_d;
   logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
   logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
   logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;
   logic                  rd_fire;

   // Grants look only at the request lines, state and last winner.
   always_comb begin
      cpu_gnt = 1'b0;
      dbg_gnt = 1'b0;
      if (!rst) begin
         if (state_q == LOCKED) begin
            dbg_gnt = dbg_req;
         end else if (cpu_req && dbg_req) begin
            if (last_winner_q == OWN_DBG) cpu_gnt = 1'b1;
            else                          dbg_gnt = 1'b1;
         end else begin
            cpu_gnt = cpu_req;
            dbg_gnt = dbg_req;
         end
      end
   end

   assign cpu_stall = cpu_req & ~cpu_gnt & ~rst;

   always_comb begin
      state_d       = state_q;
      last_winner_d = last_winner_q;
      cmd_valid_d   = cpu_gnt | dbg_gnt;
      cmd_owner_d   = cmd_owner_q;
      cmd_we_d      = cmd_we_q;
      cmd_addr_d    = cmd_addr_q;
      cmd_wdata_d   = cmd_wdata_q;

      case (state_q)
         ARB:     if (dbg_gnt && dbg_lock) state_d = LOCKED;
         LOCKED:  if ((dbg_gnt || !dbg_req) && !dbg_lock) state_d = ARB;
         default: state_d = ARB;
      endcase

      if (cpu_gnt) begin
         last_winner_d = OWN_CPU;
         cmd_owner_d   = OWN_CPU;
         cmd_we_d      = cpu_we;
         cmd_addr_d    = cpu_addr;
         cmd_wdata_d   = cpu_wdata;
      end else if (dbg_gnt) begin
         last_winner_d = OWN_DBG;
         cmd_owner_d   = OWN_DBG;
         cmd_we_d      = dbg_we;
         cmd_addr_d    = dbg_addr;
         cmd_wdata_d   = dbg_wdata;
      end
   end

   // NOTE: the command register is only cleared at the reset edge, so the
   // strobes are gated by rst to keep a stale command from reaching memory.
   assign mem_we   = ~rst & cmd_valid_q & cmd_we_q;
   assign mem_addr = cmd_addr_q;
   assign mem_wd   = cmd_wdata_q;

   assign rd_fire     = ~rst & cmd_valid_q & ~cmd_we_q;
   assign cpu_rvalid  = rd_fire & (cmd_owner_q == OWN_CPU);
   assign dbg_rvalid  = rd_fire & (cmd_owner_q == OWN_DBG);
   assign cpu_rdata   = cpu_rvalid ? mem_rd : cpu_rdata_q;
   assign dbg_rdata   = dbg_rvalid ? mem_rd : dbg_rdata_q;
   assign cpu_rdata_d = cpu_rdata;
   assign dbg_rdata_d = dbg_rdata;

   // NOTE: all state uses non-blocking assignments so every flop samples
   // the values from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ARB;
         last_winner_q <= OWN_DBG;
         cmd_valid_q   <= 1'b0;
         cmd_owner_q   <= OWN_CPU;
         cmd_we_q      <= 1'b0;
         cmd_addr_q    <= '0;
         cmd_wdata_q   <= '0;
         cpu_rdata_q   <= '0;
         dbg_rdata_q   <= '0;
      end else begin
         state_q       <= state_d;
         last_winner_q <= last_winner_d;
         cmd_valid_q   <= cmd_valid_d;
         cmd_owner_q   <= cmd_owner_d;
         cmd_we_q      <= cmd_we_d;
         cmd_addr_q    <= cmd_addr_d;
         cmd_wdata_q   <= cmd_wdata_d;
         cpu_rdata_q   <= cpu_rdata_d;
         dbg_rdata_q   <= dbg_rdata_d;
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: grant/stall/mem_we checked per cycle,
// load responses checked by a scoreboard monitor against a queue.
module tb_data_mem_arbiter;

   localparam logic [31:0] D = 32'hDEADBEEF;

   logic        clk = 1'b0;
   logic        rst;
   logic        tb_init;
   logic        cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
   logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
   logic [31:0] mem_addr, mem_wd, mem_rd;
   logic        mem_we;

   logic [31:0] mem_model [0:255];

   typedef struct {
      logic        is_dbg;
      logic [31:0] data;
   } resp_t;
   resp_t exp_q[$];

   int tests = 0;
   int fails = 0;

   data_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   always #5 clk = ~clk;

   // Single-port memory: asynchronous read, write on the rising edge.
   assign mem_rd = mem_model[mem_addr[9:2]];
   always @(posedge clk) begin
      if (tb_init) begin
         for (int i = 0; i < 256; i++) mem_model[i] <= 32'h0;
         mem_model[8] <= 32'h12345678;
         mem_model[9] <= 32'hCAFEF00D;
      end else if (mem_we) begin
         mem_model[mem_addr[9:2]] <= mem_wd;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock cycle: drive after the rising edge, check at the falling edge.
   task automatic step(input logic r,
                       input logic creq, input logic cwe, input logic [31:0] caddr, input logic [31:0] cwd,
                       input logic dreq, input logic dwe, input logic [31:0] daddr, input logic [31:0] dwd,
                       input logic dlock,
                       input logic egc, input logic egd, input logic emwe, input logic [31:0] erd,
                       input string tag);
      resp_t e;
      @(posedge clk);
      #1;
      rst = r;
      cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
      dbg_req = dreq; dbg_we = dwe; dbg_addr = daddr; dbg_wdata = dwd; dbg_lock = dlock;
      @(negedge clk);
      check({tag, " cpu_gnt"}, {31'b0, cpu_gnt}, {31'b0, egc});
      check({tag, " dbg_gnt"}, {31'b0, dbg_gnt}, {31'b0, egd});
      check({tag, " cpu_stall"}, {31'b0, cpu_stall}, {31'b0, creq & ~egc & ~r});
      check({tag, " mem_we"}, {31'b0, mem_we}, {31'b0, emwe});
      if ((egc && !cwe) || (egd && !dwe)) begin
         e.is_dbg = egd;
         e.data   = erd;
         exp_q.push_back(e);
      end
   endtask

   task automatic idle(input string tag, input logic emwe);
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0,
           1'b0, 1'b0, emwe, 32'h0, tag);
   endtask

   // Scoreboard monitor: every response is matched against the queue head.
   always @(negedge clk) begin : monitor
      resp_t e;
      if (cpu_rvalid || dbg_rvalid) begin
         check("rvalid_exclusive", {31'b0, cpu_rvalid & dbg_rvalid}, 32'h0);
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_rvalid: cpu_rvalid %b dbg_rvalid %b with empty queue",
                     cpu_rvalid, dbg_rvalid);
         end else begin
            e = exp_q.pop_front();
            check("rvalid_owner_is_dbg", {31'b0, dbg_rvalid}, {31'b0, e.is_dbg});
            check("rdata", e.is_dbg ? dbg_rdata : cpu_rdata, e.data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; tb_init = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h55;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'h0; dbg_wdata = 32'h0; dbg_lock = 1'b0;

      // Reset held two cycles with a CPU store pending.
      step(1, 1,1,32'h40,32'h55, 0,0,0,0,0, 0,0,0,0, "rst1");
      tb_init = 1'b0;
      check("rst cpu_rvalid", {31'b0, cpu_rvalid}, 32'h0);
      check("rst dbg_rvalid", {31'b0, dbg_rvalid}, 32'h0);
      check("rst cpu_rdata", cpu_rdata, 32'h0);
      check("rst dbg_rdata", dbg_rdata, 32'h0);
      check("rst mem_addr", mem_addr, 32'h0);
      check("rst mem_wd", mem_wd, 32'h0);
      step(1, 1,1,32'h40,32'h55, 0,0,0,0,0, 0,0,0,0, "rst2");

      // First grant in the release cycle; store then load of 0x10.
      step(0, 1,1,32'h40,32'h55, 0,0,0,0,0, 1,0,0,0, "rel");
      step(0, 1,1,32'h10,D,      0,0,0,0,0, 1,0,1,0, "st10");
      check("st10 mem_addr", mem_addr, 32'h40);
      check("st10 mem_wd", mem_wd, 32'h55);
      step(0, 1,0,32'h10,32'h0,  0,0,0,0,0, 1,0,1,D, "ld10");
      check("ld10 mem_addr", mem_addr, 32'h10);
      check("ld10 mem_wd", mem_wd, D);
      idle("cpu_drain", 1'b0);

      // Contention straight out of reset: CPU, DBG, CPU, DBG.
      step(1, 1,0,32'h10,0, 1,0,32'h40,0,0, 0,0,0,0, "ct_rst");
      step(0, 1,0,32'h10,0, 1,0,32'h40,0,0, 1,0,0,D,       "ct1");
      step(0, 1,0,32'h10,0, 1,0,32'h40,0,0, 0,1,0,32'h55,  "ct2");
      step(0, 1,0,32'h10,0, 1,0,32'h40,0,0, 1,0,0,D,       "ct3");
      step(0, 1,0,32'h10,0, 1,0,32'h40,0,0, 0,1,0,32'h55,  "ct4");
      idle("ct_drain", 1'b0);

      // CPU store so the CPU is last winner, then a 4-beat locked dbg burst.
      step(0, 1,1,32'h30,32'h33, 0,0,0,0,0, 1,0,0,0, "pre_lock");
      step(0, 1,0,32'h10,0, 1,1,32'h100,32'hA0,1, 0,1,1,0, "lk1");
      step(0, 1,0,32'h10,0, 1,1,32'h104,32'hA1,1, 0,1,1,0, "lk2");
      step(0, 1,0,32'h10,0, 1,1,32'h108,32'hA2,1, 0,1,1,0, "lk3");
      step(0, 1,0,32'h10,0, 1,1,32'h10C,32'hA3,0, 0,1,1,0, "lk4");
      step(0, 1,0,32'h10,0, 0,0,0,0,0,              1,0,1,D, "lk5");
      idle("lk_drain", 1'b0);
      check("mem 0x30", mem_model[12], 32'h33);
      check("mem 0x100", mem_model[64], 32'hA0);
      check("mem 0x104", mem_model[65], 32'hA1);
      check("mem 0x108", mem_model[66], 32'hA2);
      check("mem 0x10C", mem_model[67], 32'hA3);

      // Response routing: dbg load then CPU load on back-to-back cycles.
      step(0, 0,0,0,0,         1,0,32'h20,0,0, 0,1,0,32'h12345678, "rt_dbg");
      step(0, 1,0,32'h24,0,    0,0,0,0,0,      1,0,0,32'hCAFEF00D, "rt_cpu");
      check("rt cpu_rdata hold", cpu_rdata, D);
      idle("rt_drain", 1'b0);
      check("rt dbg_rdata hold", dbg_rdata, 32'h12345678);

      // Reset while LOCKED with a store in the command register.
      step(0, 1,0,32'h10,0, 1,1,32'h80,32'h77,1, 0,1,0,0, "xl_lock");
      step(1, 1,0,32'h10,0, 1,1,32'h80,32'h77,1, 0,0,0,0, "xl_rst");
      step(0, 1,0,32'h10,0, 1,1,32'h80,32'h77,1, 1,0,0,D, "xl_tie");
      idle("xl_drain", 1'b0);
      check("xl store dropped", mem_model[32], 32'h0);

      idle("final", 1'b0);
      check("scoreboard empty", exp_q.size(), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
